// File: rtl/mrd_pkg.sv
// Shared constants and helpers for the multi-rate tick divider.
// Provides default widths and rates, a frequency-to-divisor helper,
// named speed constants and the per-channel action encoding.
package mrd_pkg;

    localparam int MRD_CNT_W       = 27;
    localparam int MRD_CLK_HZ      = 50_000_000;
    localparam int MRD_DEFAULT_DIV = 50_000_000;

    // Divisor that yields one tick per period of the requested rate.
    function automatic int hz_to_div(input int hz);
        return (hz == 0) ? 0 : MRD_CLK_HZ / hz;
    endfunction

    localparam int DIV_1HZ  = hz_to_div(1);
    localparam int DIV_2HZ  = hz_to_div(2);
    localparam int DIV_10HZ = hz_to_div(10);
    localparam int DIV_60HZ = hz_to_div(60);

    // What a channel does on the coming clock edge, in priority order.
    typedef enum logic [2:0] {
        ACT_RESTART = 3'd0,  // forced clear, shadow applied
        ACT_HOLD    = 3'd1,  // paused: counter frozen, tick suppressed
        ACT_OFF     = 3'd2,  // divisor zero: idle, pending value loads
        ACT_WRAP    = 3'd3,  // end of period: tick, pending value loads
        ACT_COUNT   = 3'd4   // mid period: advance counter
    } mrd_act_e;

endpackage

// File: rtl/mrd_channel.sv
// One tick channel: period counter, active and shadow divisors, registered tick.
// MRD_SQUARE_OUT_EN adds a sq_out flop that toggles on every tick.
// A new divisor waits in the shadow register until the current period ends,
// so a period is never cut short or stretched by a reload.
module mrd_channel
    import mrd_pkg::*;
#(
    parameter int CNT_W       = MRD_CNT_W,
    parameter int DEFAULT_DIV = MRD_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pause,
    input  logic             restart,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             tick,
    output logic             pending
`ifdef MRD_SQUARE_OUT_EN
    ,
    output logic             sq_out
`endif
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] shadow_div;
    logic             last_cycle;
    mrd_act_e         act;

    // Unsigned compare; only meaningful when active_div is non-zero.
    assign last_cycle = (cnt == (active_div - ONE));

    // Select this edge's action; restart outranks pause, pause outranks counting.
    always_comb begin
        act = ACT_COUNT;
        if (restart) begin
            act = ACT_RESTART;
        end else if (pause) begin
            act = ACT_HOLD;
        end else if (active_div == '0) begin
            act = ACT_OFF;
        end else if (last_cycle) begin
            act = ACT_WRAP;
        end
    end

    // Counter, tick and active divisor; reloads only at period boundaries or restart.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            tick       <= 1'b0;
            active_div <= RESET_DIV;
        end else begin
            case (act)
                ACT_RESTART: begin
                    cnt        <= '0;
                    tick       <= 1'b0;
                    active_div <= wr ? wr_val : shadow_div;
                end
                ACT_HOLD: begin
                    tick <= 1'b0;
                end
                ACT_OFF: begin
                    cnt  <= '0;
                    tick <= 1'b0;
                    if (pending) begin
                        active_div <= shadow_div;
                    end
                end
                ACT_WRAP: begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    if (pending) begin
                        active_div <= shadow_div;
                    end
                end
                default: begin
                    cnt  <= cnt + ONE;
                    tick <= 1'b0;
                end
            endcase
        end
    end

    // Shadow divisor and pending flag; a write on a load edge stays pending for the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_div <= RESET_DIV;
            pending    <= 1'b0;
        end else if (restart) begin
            if (wr) begin
                shadow_div <= wr_val;
            end
            pending <= 1'b0;
        end else if (wr) begin
            shadow_div <= wr_val;
            pending    <= 1'b1;
        end else if (act == ACT_OFF || act == ACT_WRAP) begin
            pending <= 1'b0;
        end
    end

`ifdef MRD_SQUARE_OUT_EN
    // Square wave: flips on each tick-raising edge, holds through pause, clears on restart.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sq_out <= 1'b0;
        end else if (act == ACT_RESTART) begin
            sq_out <= 1'b0;
        end else if (act == ACT_WRAP) begin
            sq_out <= ~sq_out;
        end
    end
`endif

endmodule

// File: rtl/multi_rate_divider.sv
// Multi-channel programmable tick generator.
// Decodes the shared divisor write port into per-channel strobes and
// instantiates NUM_CH independent mrd_channel counters sharing one pause.
// MRD_SQUARE_OUT_EN adds the sq_out port with one square-wave output per channel.
module multi_rate_divider
    import mrd_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = MRD_CNT_W,
    parameter int CLK_HZ      = MRD_CLK_HZ,
    parameter int DEFAULT_DIV = CLK_HZ,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pause,
    input  logic [NUM_CH-1:0] restart,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_pending
`ifdef MRD_SQUARE_OUT_EN
    ,
    output logic [NUM_CH-1:0] sq_out
`endif
);

    logic [NUM_CH-1:0] wr_en;

    // One-hot write strobe; indices beyond the last channel are dropped.
    always_comb begin
        wr_en = '0;
        if (div_wr && (int'(div_ch) < NUM_CH)) begin
            wr_en[div_ch] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mrd_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_channel (
            .clk    (clk),
            .resetn (resetn),
            .pause  (pause),
            .restart(restart[i]),
            .wr     (wr_en[i]),
            .wr_val (div_val),
            .tick   (tick[i]),
            .pending(div_pending[i])
`ifdef MRD_SQUARE_OUT_EN
            ,
            .sq_out (sq_out[i])
`endif
        );
    end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Scoreboard bench for multi_rate_divider (NUM_CH=4, DEFAULT_DIV=8).
// The reference model counts unpaused cycles remaining until each channel's next tick.
module tb_multi_rate_divider;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int DDIV   = 8;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              pause = 1'b0;
    logic [NUM_CH-1:0] restart = '0;
    logic              div_wr = 1'b0;
    logic [1:0]        div_ch = '0;
    logic [CNT_W-1:0]  div_val = '0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] div_pending;
`ifdef MRD_SQUARE_OUT_EN
    logic [NUM_CH-1:0] sq_out;
`endif

    always #5 clk = ~clk;

    multi_rate_divider #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .CLK_HZ     (64),
        .DEFAULT_DIV(DDIV)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pause      (pause),
        .restart    (restart),
        .div_wr     (div_wr),
        .div_ch     (div_ch),
        .div_val    (div_val),
        .tick       (tick),
        .div_pending(div_pending)
`ifdef MRD_SQUARE_OUT_EN
        ,
        .sq_out     (sq_out)
`endif
    );

    typedef struct {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] pend;
        logic [NUM_CH-1:0] sq;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle_no = 0;

    int m_div[NUM_CH];
    int m_shadow[NUM_CH];
    int m_left[NUM_CH];
    bit m_pend[NUM_CH];
    bit m_tick[NUM_CH];
    bit m_sq[NUM_CH];

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = DDIV; m_shadow[i] = DDIV; m_left[i] = DDIV;
            m_pend[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
        end
    endtask

    task automatic model_step(input bit p, input logic [NUM_CH-1:0] rs,
                              input bit wr, input int ch, input int val);
        for (int i = 0; i < NUM_CH; i++) begin
            bit w;
            w = wr && (ch == i);
            if (rs[i]) begin
                m_div[i]    = w ? val : m_shadow[i];
                m_shadow[i] = m_div[i];
                m_pend[i]   = 0;
                m_left[i]   = m_div[i];
                m_tick[i]   = 0;
                m_sq[i]     = 0;
            end else begin
                m_tick[i] = 0;
                if (!p) begin
                    if (m_div[i] == 0) begin
                        if (m_pend[i]) begin
                            m_div[i]  = m_shadow[i];
                            m_pend[i] = 0;
                            m_left[i] = m_div[i];
                        end
                    end else begin
                        m_left[i] = m_left[i] - 1;
                        if (m_left[i] == 0) begin
                            m_tick[i] = 1;
                            m_sq[i]   = ~m_sq[i];
                            if (m_pend[i]) begin
                                m_div[i]  = m_shadow[i];
                                m_pend[i] = 0;
                            end
                            m_left[i] = m_div[i];
                        end
                    end
                end
                if (w) begin
                    m_shadow[i] = val;
                    m_pend[i]   = 1;
                end
            end
        end
    endtask

    // Starts and ends on a falling edge; inputs are held across the rising edge.
    task automatic drive(input bit p, input logic [NUM_CH-1:0] rs,
                         input bit wr, input int ch, input int val);
        exp_t e;
        pause   = p;
        restart = rs;
        div_wr  = wr;
        div_ch  = 2'(ch);
        div_val = CNT_W'(val);
        model_step(p, rs, wr, ch, val);
        for (int i = 0; i < NUM_CH; i++) begin
            e.tick[i] = m_tick[i];
            e.pend[i] = m_pend[i];
            e.sq[i]   = m_sq[i];
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, '0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2;
        resetn = 1'b0;
        #1;
        vectors++;
        if (tick !== '0 || div_pending !== '0) begin
            miscompares++;
            $display("FAIL reset_state: tick=%b pending=%b, required tick=0000 pending=0000",
                     tick, div_pending);
        end
`ifdef MRD_SQUARE_OUT_EN
        vectors++;
        if (sq_out !== '0) begin
            miscompares++;
            $display("FAIL reset_sq: sq_out=%b, required 0000", sq_out);
        end
`endif
        pause = 0; restart = '0; div_wr = 0; div_ch = '0; div_val = '0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        cycle_no = 0;
    endtask

    // Monitor: compare each registered output against the queued expectation.
    always @(posedge clk) begin
        #2;
        if (resetn && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cycle_no++;
            vectors++;
            if (tick !== e.tick || div_pending !== e.pend
`ifdef MRD_SQUARE_OUT_EN
                || sq_out !== e.sq
`endif
            ) begin
                miscompares++;
`ifdef MRD_SQUARE_OUT_EN
                $display("FAIL edge%0d: tick=%b pending=%b sq=%b, required tick=%b pending=%b sq=%b",
                         cycle_no, tick, div_pending, sq_out, e.tick, e.pend, e.sq);
`else
                $display("FAIL edge%0d: tick=%b pending=%b, required tick=%b pending=%b",
                         cycle_no, tick, div_pending, e.tick, e.pend);
`endif
            end
        end
    end

    initial begin
        int p, wr, ch, val, r;
        logic [NUM_CH-1:0] rs;
        @(negedge clk);
        do_reset();
        // Free run: ticks on edges 8, 16, 24.
        idle(24);
        // Divisor write on ch1 at edge 5: ticks at 8, 11, 14.
        do_reset();
        idle(4);
        drive(0, '0, 1, 1, 3);
        idle(12);
        // Pause over edges 3..9.
        do_reset();
        idle(2);
        for (int k = 0; k < 7; k++) drive(1, '0, 0, 0, 0);
        idle(12);
        // Restart ch2 with a same-cycle write of 2.
        do_reset();
        idle(5);
        drive(0, 4'b0100, 1, 2, 2);
        idle(8);
        // Disable ch3, then divisor 1.
        drive(0, '0, 1, 3, 0);
        idle(12);
        drive(0, '0, 1, 3, 1);
        idle(6);
        // Write on the wrap edge of ch0 (edge 8 of a fresh run).
        do_reset();
        idle(7);
        drive(0, '0, 1, 0, 5);
        idle(12);
        // Mid-period reset, then free run.
        idle(3);
        do_reset();
        idle(18);
        // Randomised traffic with occasional asynchronous resets.
        for (int n = 0; n < 1500; n++) begin
            if (n % 500 == 250) do_reset();
            p  = ($urandom_range(0, 99) < 12) ? 1 : 0;
            for (int i = 0; i < NUM_CH; i++) rs[i] = ($urandom_range(0, 99) < 3);
            wr = ($urandom_range(0, 99) < 15) ? 1 : 0;
            ch = $urandom_range(0, NUM_CH - 1);
            r  = $urandom_range(0, 9);
            val = (r == 0) ? 0 : (r == 1) ? 1 : $urandom_range(2, 12);
            drive(p[0], rs, wr[0], ch, val);
        end
        idle(2);
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
